read_pointers: RTL and testbench

- Read-side address/enable controller for the single-port-write, single-port-read RAM buffer. Pairs with the existing write-pointer block (push -> w_en/w_add).
- Tracks buffer occupancy from the writer's registered w_en pulses and the consumer's pop requests.
- Issues r_en/r_add to the RAM and a delayed rd_valid aligned with RAM read data.
- Flags empty/full and sticky overflow/underflow errors.

---
 rtl/read_pointers_if.sv | 26 ++
 rtl/read_pointers.sv | 109 ++++++++++
 tb/tb_read_pointers.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/read_pointers_if.sv
// rtl/read_pointers_if.sv - write/pop/status bundle between the read-pointer block and its neighbours
interface read_pointers_if #(
    parameter int AW = 4
);
    logic          w_en;
    logic          pop;
    logic          clr_err;
    logic [AW-1:0] r_add;
    logic          r_en;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport slave (
        input  w_en, pop, clr_err,
        output r_add, r_en, rd_valid, empty, full, count, overflow, underflow
    );

    modport master (
        output w_en, pop, clr_err,
        input  r_add, r_en, rd_valid, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/read_pointers.sv
// rtl/read_pointers.sv - read-side address/enable controller with occupancy tracking and error flags
module read_pointers #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    read_pointers_if.slave bus
);
    localparam logic [1:0]    S_EMPTY   = 2'd0;
    localparam logic [1:0]    S_AVAIL   = 2'd1;
    localparam logic [1:0]    S_FULL    = 2'd2;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [AW:0]       cnt;
    logic [AW:0]       cnt_next;
    logic [AW-1:0]     ptr;
    logic              ren;
    logic [RD_LAT-1:0] lat_sr;
    logic              ovf;
    logic              unf;
    logic              accept;
    logic              ovf_evt;
    logic              unf_evt;

    // A write in the same cycle never makes an empty buffer poppable.
    assign accept  = bus.pop && (cnt != '0);
    assign ovf_evt = bus.w_en && !accept && (cnt == FULL_CNT);
    assign unf_evt = bus.pop && (cnt == '0);

    always_comb begin
        cnt_next = cnt;
        if (bus.w_en && !accept && (cnt != FULL_CNT)) begin
            cnt_next = cnt + ONE_CNT;
        end else if (accept && !bus.w_en) begin
            cnt_next = cnt - ONE_CNT;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (bus.w_en) begin
                    state_next = S_AVAIL;
                end
            end
            S_AVAIL: begin
                if ((cnt == ONE_CNT) && accept && !bus.w_en) begin
                    state_next = S_EMPTY;
                end else if ((cnt == FULL_CNT - ONE_CNT) && bus.w_en && !accept) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (accept && !bus.w_en) begin
                    state_next = S_AVAIL;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_EMPTY;
            cnt   <= '0;
            ptr   <= '0;
            ren   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ren   <= accept;
            // The writer's first word lands at address 1, so the pointer is pre-incremented.
            if (accept) begin
                ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
            end
            ovf <= ovf_evt || (ovf && !bus.clr_err);
            unf <= unf_evt || (unf && !bus.clr_err);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_sr <= '0;
        end else begin
            lat_sr[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_sr[i] <= lat_sr[i-1];
            end
        end
    end

    assign bus.r_add     = ptr;
    assign bus.r_en      = ren;
    assign bus.rd_valid  = lat_sr[RD_LAT-1];
    assign bus.empty     = (state == S_EMPTY);
    assign bus.full      = (state == S_FULL);
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
endmodule

// File: tb/tb_read_pointers.sv
// tb/tb_read_pointers.sv - scoreboard bench for read_pointers with RD_LAT of 1 and 3
module tb_read_pointers;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n;

    read_pointers_if #(.AW(AW)) b1 ();
    read_pointers_if #(.AW(AW)) b3 ();

    assign b3.w_en    = b1.w_en;
    assign b3.pop     = b1.pop;
    assign b3.clr_err = b1.clr_err;

    read_pointers #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(1)) dut1 (.clk(clk), .reset(rst_n), .bus(b1));
    read_pointers #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_count, m_ptr, cyc;
    bit m_ren, m_ovf, m_unf;
    int q1[$], q3[$], st1[$], st3[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_ptr = 0; m_ren = 0; m_ovf = 0; m_unf = 0;
        q1.delete(); q3.delete(); st1.delete(); st3.delete();
    endtask

    // Reference behaviour in plain integer terms, applied at each rising edge.
    task automatic step(input bit w, input bit p, input bit c);
        bit acc;
        b1.w_en = w; b1.pop = p; b1.clr_err = c;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc   = p && (m_count > 0);
            m_ovf = (w && !acc && m_count == DEPTH) || (m_ovf && !c);
            m_unf = (p && m_count == 0) || (m_unf && !c);
            m_count = m_count + int'(w) - int'(acc);
            if (m_count > DEPTH) m_count = DEPTH;
            m_ren = acc;
            if (acc) begin
                m_ptr = (m_ptr + 1) % DEPTH;
                q1.push_back(m_ptr);
                q3.push_back(m_ptr);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) step(0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        b1.w_en = 1'b0; b1.pop = 1'b0; b1.clr_err = 1'b0;
        cyc = 0;
        model_reset();
        fork
            begin : stimulus
                do_reset();
                chk("reset_count", int'(b1.count), 0);
                chk("reset_empty", int'(b1.empty), 1);
                chk("reset_r_add", int'(b1.r_add), 0);

                repeat (3) step(1, 0, 0);
                chk("three_writes_count", int'(b1.count), 3);
                repeat (3) step(0, 1, 0);
                repeat (4) step(0, 0, 0);
                chk("drained_count", int'(b1.count), 0);
                chk("drained_empty", int'(b1.empty), 1);

                repeat (16) step(1, 0, 0);
                chk("fill_full", int'(b1.full), 1);
                chk("fill_count", int'(b1.count), 16);
                step(1, 0, 0);
                chk("ovf_set", int'(b1.overflow), 1);
                chk("ovf_count_sat", int'(b1.count), 16);
                step(0, 0, 1);
                chk("ovf_cleared", int'(b1.overflow), 0);

                do_reset();
                repeat (16) step(1, 0, 0);
                repeat (20) step(1, 1, 0);
                chk("wrap_count", int'(b1.count), 16);
                chk("wrap_no_ovf", int'(b1.overflow), 0);
                chk("wrap_last_r_add", int'(b1.r_add), 4);

                do_reset();
                step(0, 1, 0);
                step(0, 0, 0);
                chk("unf_r_en", int'(b1.r_en), 0);
                chk("unf_r_add", int'(b1.r_add), 0);
                chk("unf_set", int'(b1.underflow), 1);
                step(1, 1, 0);
                step(0, 0, 0);
                chk("no_fallthrough_count", int'(b1.count), 1);

                do_reset();
                repeat (4) step(1, 0, 0);
                step(0, 1, 0);
                step(0, 1, 0);
                chk("inflight_r_en", int'(b3.r_en), 1);
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("async_r_en", int'(b3.r_en), 0);
                chk("async_rd_valid", int'(b3.rd_valid), 0);
                chk("async_r_add", int'(b3.r_add), 0);
                chk("async_count", int'(b3.count), 0);
                chk("async_empty", int'(b3.empty), 1);
                chk("async_full", int'(b3.full), 0);
                repeat (4) step(0, 0, 0);
                rst_n = 1'b1;

                repeat (10000) begin
                    step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                         $urandom_range(0, 99) < 3);
                end
                repeat (6) step(0, 0, 0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    cyc++;
                    chk("count", int'(b1.count), m_count);
                    chk("empty", int'(b1.empty), int'(m_count == 0));
                    chk("full", int'(b1.full), int'(m_count == DEPTH));
                    chk("state_vs_count", int'(b1.empty), int'(b1.count == 0));
                    chk("overflow", int'(b1.overflow), int'(m_ovf));
                    chk("underflow", int'(b1.underflow), int'(m_unf));
                    chk("r_add", int'(b1.r_add), m_ptr);
                    chk("r_en1", int'(b1.r_en), int'(m_ren));
                    chk("r_en3", int'(b3.r_en), int'(m_ren));
                    chk("count3", int'(b3.count), m_count);
                    if (b1.rd_valid) begin
                        chk("rd_valid1_pending", int'(st1.size() > 0), 1);
                        if (st1.size() > 0) chk("rd_valid1_lat", cyc - st1.pop_front(), 1);
                    end
                    if (b3.rd_valid) begin
                        chk("rd_valid3_pending", int'(st3.size() > 0), 1);
                        if (st3.size() > 0) chk("rd_valid3_lat", cyc - st3.pop_front(), 3);
                    end
                    if (b1.r_en) begin
                        chk("r_en1_expected", int'(q1.size() > 0), 1);
                        if (q1.size() > 0) chk("r_add1_order", int'(b1.r_add), q1.pop_front());
                        st1.push_back(cyc);
                    end
                    if (b3.r_en) begin
                        chk("r_en3_expected", int'(q3.size() > 0), 1);
                        if (q3.size() > 0) chk("r_add3_order", int'(b3.r_add), q3.pop_front());
                        st3.push_back(cyc);
                    end
                end
            end
        join_any
        disable fork;
        chk("reads_left1", q1.size(), 0);
        chk("reads_left3", q3.size(), 0);
        chk("valid_left1", st1.size(), 0);
        chk("valid_left3", st3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
